shift_add_sequencer: RTL

Control unit for the shift-add multiplier datapath. It accepts a start request, initialises the accumulator/multiplier register, then runs N iterations. Each iteration examines the multiplier LSB, optionally commands an add, then commands a shift. It signals completion with a one-cycle done pulse. It sits directly upstream of the accumulator register, drives that register's reset/add/shift controls, and reads back bit 0 of the register's AQ output.

---
 rtl/shift_mult_pkg.sv | 19 +
 rtl/iteration_counter.sv | 37 +++
 rtl/shift_add_sequencer.sv | 90 +++++++++
 3 files changed

// File: rtl/shift_mult_pkg.sv
// Shared types and helpers for the shift-add multiplier: sequencer states
// and the iteration-counter width rule.
package shift_mult_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        EXAMINE = 3'd2,
        ADD     = 3'd3,
        SHIFT   = 3'd4,
        DONE    = 3'd5
    } seq_state_t;

    // Counter must hold the value n itself, hence n+1.
    function automatic int unsigned cw(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/iteration_counter.sv
// Loadable down-counter that saturates at zero; is_one is registered
// alongside the count so the sequencer sees it glitch-free.
module iteration_counter #(
    parameter int unsigned W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         is_one
);

    logic [W-1:0] count_nxt;

    // Load wins over decrement; decrement never wraps below zero.
    always_comb begin
        count_nxt = count;
        if (load) begin
            count_nxt = load_value;
        end else if (dec && (count != W'(0))) begin
            count_nxt = count - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            is_one <= 1'b0;
        end else begin
            count  <= count_nxt;
            is_one <= (count_nxt == W'(1));
        end
    end

endmodule

// File: rtl/shift_add_sequencer.sv
// Control FSM for the shift-add multiplier: clears the AQ register, then
// per multiplier bit optionally adds and always shifts, then pulses done.
module shift_add_sequencer
    import shift_mult_pkg::*;
#(
    parameter  int unsigned n  = 4,
    localparam int unsigned CW = cw(n)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic          Q0,
    output logic          clear,
    output logic          add,
    output logic          shift,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] count
);

    seq_state_t state;
    seq_state_t state_nxt;
    logic       clear_nxt;
    logic       add_nxt;
    logic       shift_nxt;
    logic       busy_nxt;
    logic       done_nxt;
    logic       cnt_load;
    logic       cnt_dec;
    logic       cnt_is_one;

    iteration_counter #(
        .W (CW)
    ) u_iteration_counter (
        .clk        (clock),
        .rst_n      (reset),
        .load       (cnt_load),
        .load_value (CW'(n)),
        .dec        (cnt_dec),
        .count      (count),
        .is_one     (cnt_is_one)
    );

    assign cnt_load = (state == LOAD);
    assign cnt_dec  = (state == SHIFT);

    // Next state; Q0 is consulted only in EXAMINE so it is a don't-care elsewhere.
    always_comb begin
        state_nxt = state;
        clear_nxt = 1'b0;
        add_nxt   = 1'b0;
        shift_nxt = 1'b0;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            IDLE:    if (start) state_nxt = LOAD;
            LOAD:    state_nxt = EXAMINE;
            EXAMINE: state_nxt = Q0 ? ADD : SHIFT;
            ADD:     state_nxt = SHIFT;
            SHIFT:   state_nxt = cnt_is_one ? DONE : EXAMINE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // Commands are decoded from the next state and registered with it.
        clear_nxt = (state_nxt == LOAD);
        add_nxt   = (state_nxt == ADD);
        shift_nxt = (state_nxt == SHIFT);
        done_nxt  = (state_nxt == DONE);
        busy_nxt  = (state_nxt != IDLE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            clear <= 1'b0;
            add   <= 1'b0;
            shift <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            clear <= clear_nxt;
            add   <= add_nxt;
            shift <= shift_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
        end
    end

endmodule
